l1i_mau: RTL and testbench

Line-fill memory access unit for the L1 instruction cache. It accepts a line-miss request from the cache's MAU port and fetches the line as a sequence of single-word beats on the narrow memory bus. It assembles the beats into a line buffer and returns the full line with a one-cycle acknowledge pulse. It sits directly downstream of the L1I cache and upstream of the memory bus.

---
 rtl/l1_pkg.sv | 21 ++
 rtl/l1i_mau.sv | 83 ++++++++
 tb/tb_l1i_mau.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/l1_pkg.sv
// rtl/l1_pkg.sv - shared L1 instruction-cache sizes, FSM state type and line address helper
package l1_pkg;

    localparam int CORE_ADDR_WIDTH = 32;
    localparam int L1_LINE_SIZE    = 128;
    localparam int L1_BUS_WIDTH    = 32;
    localparam int BEATS           = L1_LINE_SIZE / L1_BUS_WIDTH;
    localparam int BEAT_IDX_W      = $clog2(BEATS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } mau_state_e;

    // Line base of a word address; also used by the cache for its tag/index slicing.
    function automatic logic [CORE_ADDR_WIDTH-1:0] line_base(input logic [CORE_ADDR_WIDTH-1:0] addr);
        return {addr[CORE_ADDR_WIDTH-1:BEAT_IDX_W], {BEAT_IDX_W{1'b0}}};
    endfunction

endpackage

// File: rtl/l1i_mau.sv
// rtl/l1i_mau.sv - L1I line-fill unit: fetches a line as ascending single-word beats, acks once
module l1i_mau
    import l1_pkg::*;
#(
    parameter int ADDR_WIDTH = CORE_ADDR_WIDTH,
    parameter int LINE_SIZE  = L1_LINE_SIZE,
    parameter int BUS_WIDTH  = L1_BUS_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mau_req_val,
    input  logic [ADDR_WIDTH-1:0] mau_req_addr,
    output logic                  mau_req_ack,
    output logic [LINE_SIZE-1:0]  mau_ack_data,
    output logic                  mem_req_val,
    output logic [ADDR_WIDTH-1:0] mem_req_addr,
    input  logic                  mem_req_ack,
    input  logic [BUS_WIDTH-1:0]  mem_ack_data
);

    localparam int                    N_BEATS   = LINE_SIZE / BUS_WIDTH;
    localparam int                    IDX_W     = $clog2(N_BEATS);
    localparam logic [ADDR_WIDTH-1:0] OFS_MASK  = ADDR_WIDTH'(N_BEATS - 1);
    localparam logic [IDX_W-1:0]      LAST_BEAT = IDX_W'(N_BEATS - 1);

    mau_state_e            state;
    logic [IDX_W-1:0]      beat_cnt;
    logic [ADDR_WIDTH-1:0] line_base_q;
    logic [LINE_SIZE-1:0]  line_buf;
    logic                  line_match;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            beat_cnt    <= '0;
            line_base_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (mau_req_val) begin
                        line_base_q <= mau_req_addr & ~OFS_MASK;
                        beat_cnt    <= '0;
                        state       <= FILL;
                    end
                end
                FILL: begin
                    if (mem_req_ack) begin
                        beat_cnt <= beat_cnt + IDX_W'(1);
                        if (beat_cnt == LAST_BEAT) begin
                            state <= DONE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line_buf <= '0;
        end else if (state == FILL && mem_req_ack) begin
            line_buf[beat_cnt*BUS_WIDTH +: BUS_WIDTH] <= mem_ack_data;
        end
    end

    // A request withdrawn or moved during the fill fails this check and the line is dropped.
    assign line_match   = (mau_req_addr & ~OFS_MASK) == line_base_q;
    assign mau_req_ack  = (state == DONE) && mau_req_val && line_match;
    assign mau_ack_data = line_buf;
    assign mem_req_val  = (state == FILL);
    assign mem_req_addr = line_base_q | ADDR_WIDTH'(beat_cnt);

`ifndef NO_L1_ASSERTIONS
    a_mem_hold: assert property (@(posedge clk) disable iff (rst)
        mem_req_val && !mem_req_ack |=> mem_req_val && $stable(mem_req_addr));
    a_ack_single: assert property (@(posedge clk) disable iff (rst)
        mau_req_ack |=> !mau_req_ack);
    a_base_aligned: assert property (@(posedge clk) disable iff (rst)
        (line_base_q & OFS_MASK) == '0);
`endif

endmodule

// File: tb/tb_l1i_mau.sv
// tb/tb_l1i_mau.sv - self-checking bench for l1i_mau: vector table, corner sequences, random fills
module tb_l1i_mau;

    localparam int AW = 32;
    localparam int LS = 128;
    localparam int BW = 32;
    localparam int NB = LS / BW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          mau_req_val = 1'b0;
    logic [AW-1:0] mau_req_addr = '0;
    logic          mau_req_ack;
    logic [LS-1:0] mau_ack_data;
    logic          mem_req_val;
    logic [AW-1:0] mem_req_addr;
    logic          mem_req_ack = 1'b0;
    logic [BW-1:0] mem_ack_data = '0;

    l1i_mau #(.ADDR_WIDTH(AW), .LINE_SIZE(LS), .BUS_WIDTH(BW)) dut (
        .clk          (clk),
        .rst          (rst),
        .mau_req_val  (mau_req_val),
        .mau_req_addr (mau_req_addr),
        .mau_req_ack  (mau_req_ack),
        .mau_ack_data (mau_ack_data),
        .mem_req_val  (mem_req_val),
        .mem_req_addr (mem_req_addr),
        .mem_req_ack  (mem_req_ack),
        .mem_ack_data (mem_ack_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          wait_n;
        int          drop_at;
        int          chg_at;
        logic [31:0] chg_addr;
        int          run;
        int          exp_beats;
        int          exp_ack;
        logic [31:0] exp_line;
    } vec_t;

    int           total = 0;
    int           bad = 0;
    int           cyc = 0;
    int           base_cyc = 0;
    int           stall = 0;
    int           cur_wait = 0;
    bit           rnd_wait = 1'b0;
    logic [31:0]  salt = '0;
    bit           prev_hold = 1'b0;
    logic [31:0]  prev_addr = '0;
    logic [31:0]  bq_addr[$];
    int           bq_cyc[$];
    int           used_w[$];
    int           aq_cyc[$];
    logic [127:0] aq_data[$];
    vec_t         vt[7];

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (32'hA000 + a) ^ salt;
    endfunction

    function automatic logic [127:0] line_of(input logic [31:0] a);
        logic [127:0] l;
        for (int i = 0; i < NB; i++) l[i*BW +: BW] = memf((a & ~32'h3) + 32'(i));
        return l;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic clear();
        bq_addr.delete(); bq_cyc.delete(); used_w.delete();
        aq_cyc.delete(); aq_data.delete();
        base_cyc = cyc;
    endtask

    // One bus cycle: drive request, answer memory, sample, advance to just after the next edge.
    task automatic do_cycle(input logic rv, input logic [31:0] ra);
        mau_req_val  = rv;
        mau_req_addr = ra;
        if (mem_req_val) begin
            if (prev_hold) chk("addr_hold", mem_req_addr, prev_addr);
            if (stall < cur_wait) begin
                mem_req_ack = 1'b0; mem_ack_data = $urandom; stall++;
            end else begin
                mem_req_ack = 1'b1; mem_ack_data = memf(mem_req_addr); stall = 0;
            end
        end else begin
            mem_req_ack = 1'b0; mem_ack_data = $urandom; stall = 0;
        end
        #1;
        if (mem_req_val && mem_req_ack) begin
            bq_addr.push_back(mem_req_addr);
            bq_cyc.push_back(cyc - base_cyc);
            used_w.push_back(cur_wait);
            if (rnd_wait) cur_wait = $urandom_range(0, 3);
        end
        if (mau_req_ack) begin
            aq_cyc.push_back(cyc - base_cyc);
            aq_data.push_back(mau_ack_data);
        end
        prev_hold = mem_req_val && !mem_req_ack;
        prev_addr = mem_req_addr;
        @(posedge clk); #1; cyc++;
    endtask

    task automatic run_vec(input vec_t v, input string nm);
        logic        rv;
        logic [31:0] a;
        int          nb;
        clear();
        rnd_wait = 1'b0;
        cur_wait = v.wait_n;
        for (int c = 0; c < v.run; c++) begin
            rv = (aq_cyc.size() == 0) && (v.drop_at < 0 || c < v.drop_at);
            a  = (v.chg_at >= 0 && c >= v.chg_at) ? v.chg_addr : v.addr;
            do_cycle(rv, a);
        end
        chk({nm, "_nbeats"}, 128'(bq_addr.size()), 128'(v.exp_beats));
        nb = (bq_addr.size() < NB) ? bq_addr.size() : NB;
        for (int i = 0; i < nb; i++) begin
            chk({nm, "_beat_addr"}, bq_addr[i], (v.addr & ~32'h3) + 32'(i));
            chk({nm, "_beat_cyc"}, 128'(bq_cyc[i]), 128'((i + 1) * (v.wait_n + 1)));
        end
        for (int i = NB; i < bq_addr.size(); i++)
            chk({nm, "_beat2_addr"}, bq_addr[i], (v.chg_addr & ~32'h3) + 32'(i - NB));
        chk({nm, "_nacks"}, 128'(aq_cyc.size()), (v.exp_ack >= 0) ? 128'd1 : 128'd0);
        if (aq_cyc.size() > 0 && v.exp_ack >= 0) begin
            chk({nm, "_ack_cyc"}, 128'(aq_cyc[0]), 128'(v.exp_ack));
            chk({nm, "_ack_data"}, aq_data[0], line_of(v.exp_line));
        end
        chk({nm, "_end_idle"}, 128'(mem_req_val), 128'd0);
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        int          gap;
        int          exp_t;
        vec_t        vr;

        vt[0] = '{32'h100,       0, -1, -1, 32'h0,    7, 4,  5, 32'h100};
        vt[1] = '{32'h180,       3, -1, -1, 32'h0,   19, 4, 17, 32'h180};
        vt[2] = '{32'h200,       0,  2, -1, 32'h0,    8, 4, -1, 32'h0};
        vt[3] = '{32'h300,       0, -1,  2, 32'h340, 13, 8, 11, 32'h340};
        vt[4] = '{32'h7FC,       1, -1, -1, 32'h0,   11, 4,  9, 32'h7FC};
        vt[5] = '{32'h105,       0, -1, -1, 32'h0,    7, 4,  5, 32'h104};
        vt[6] = '{32'hFFFF_FFFC, 2, -1, -1, 32'h0,   15, 4, 13, 32'hFFFF_FFFC};

        @(posedge clk); @(posedge clk); #1;
        chk("rst_mem_val",  128'(mem_req_val),  128'd0);
        chk("rst_mem_addr", 128'(mem_req_addr), 128'd0);
        chk("rst_ack",      128'(mau_req_ack),  128'd0);
        chk("rst_data",     mau_ack_data,       128'd0);
        rst = 1'b0;
        do_cycle(1'b0, 32'h0);

        chk("plan_line_0x100", line_of(32'h100), 128'h0000A103_0000A102_0000A101_0000A100);
        for (int k = 0; k < 7; k++) begin
            run_vec(vt[k], $sformatf("vec%0d", k));
            do_cycle(1'b0, 32'h0);
        end

        // Reset in the middle of a fill, after beat 1 has been accepted.
        clear();
        rnd_wait = 1'b0;
        cur_wait = 0;
        for (int c = 0; c < 3; c++) do_cycle(1'b1, 32'h100);
        chk("midrst_beats_before", 128'(bq_addr.size()), 128'd2);
        rst = 1'b1;
        mau_req_val = 1'b0;
        #1;
        chk("midrst_mem_val",  128'(mem_req_val),  128'd0);
        chk("midrst_mem_addr", 128'(mem_req_addr), 128'd0);
        chk("midrst_ack",      128'(mau_req_ack),  128'd0);
        chk("midrst_data",     mau_ack_data,       128'd0);
        prev_hold = 1'b0;
        stall = 0;
        @(posedge clk); #1; cyc++;
        rst = 1'b0;
        clear();
        for (int c = 0; c < 6; c++) do_cycle(1'b0, 32'h100);
        chk("midrst_no_beats", 128'(bq_addr.size()), 128'd0);
        chk("midrst_no_ack",   128'(aq_cyc.size()),  128'd0);
        vr = vt[0];
        run_vec(vr, "postrst");
        do_cycle(1'b0, 32'h0);

        // Back-to-back: new line presented in the cycle right after the first ack.
        a = 32'h500;
        b = 32'h540;
        clear();
        cur_wait = 0;
        for (int c = 0; c < 16; c++)
            do_cycle(aq_cyc.size() < 2, (aq_cyc.size() == 0) ? a : b);
        chk("b2b_nacks",  128'(aq_cyc.size()),  128'd2);
        chk("b2b_nbeats", 128'(bq_addr.size()), 128'd8);
        if (aq_cyc.size() == 2) begin
            chk("b2b_first_cyc", 128'(aq_cyc[0]), 128'd5);
            chk("b2b_spacing",   128'(aq_cyc[1] - aq_cyc[0]), 128'(NB + 2));
            chk("b2b_data_a",    aq_data[0], line_of(a));
            chk("b2b_data_b",    aq_data[1], line_of(b));
        end
        do_cycle(1'b0, 32'h0);

        // Random fills with random per-beat wait states and random idle gaps.
        rnd_wait = 1'b1;
        for (int n = 0; n < 25; n++) begin
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) do_cycle(1'b0, $urandom);
            salt = $urandom;
            a = $urandom & 32'hFFFF_FFFC;
            clear();
            cur_wait = $urandom_range(0, 3);
            for (int c = 0; c < 40 && aq_cyc.size() == 0; c++) do_cycle(1'b1, a);
            exp_t = 1;
            foreach (used_w[i]) exp_t += used_w[i] + 1;
            chk("rnd_nacks",  128'(aq_cyc.size()),  128'd1);
            chk("rnd_nbeats", 128'(bq_addr.size()), 128'(NB));
            foreach (bq_addr[i]) chk("rnd_beat_addr", bq_addr[i], a + 32'(i));
            if (aq_cyc.size() > 0) begin
                chk("rnd_ack_cyc",  128'(aq_cyc[0]), 128'(exp_t));
                chk("rnd_ack_data", aq_data[0], line_of(a));
            end
        end
        do_cycle(1'b0, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
